// File: rtl/icache_wb.sv
// Direct-mapped read-only instruction cache in front of a classic Wishbone master port.
// Hits return in the same cycle; misses refill the whole line base-upward, then answer.
module icache_wb #(
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        flush,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i
);
    localparam int WB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TB = 30 - WB - IB;
    localparam logic [WB-1:0] LAST_BEAT = WB'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [WB-1:0]   beat_q, beat_d;
    logic [31:0]     base_q, base_d;
    logic            flush_pend_q, flush_pend_d;
    logic [SETS-1:0] valid_q, valid_d;

    logic [TB-1:0]   tag_mem  [SETS];
    logic [31:0]     data_mem [SETS][LINE_WORDS];

    logic [WB-1:0]   req_word;
    logic [IB-1:0]   req_idx;
    logic [TB-1:0]   req_tag;
    logic [IB-1:0]   fill_idx;
    logic [TB-1:0]   fill_tag;
    logic            hit;
    logic            data_we;
    logic            last_beat;
    logic            unused_byte_offset;

    assign req_word  = cpu_addr[WB+1:2];
    assign req_idx   = cpu_addr[WB+IB+1:WB+2];
    assign req_tag   = cpu_addr[31:WB+IB+2];
    assign fill_idx  = base_q[WB+IB+1:WB+2];
    assign fill_tag  = base_q[31:WB+IB+2];
    assign unused_byte_offset = ^cpu_addr[1:0];

    assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign data_we   = (state_q == S_REFILL) && wb_ack_i;
    assign last_beat = (beat_q == LAST_BEAT);

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        base_d       = base_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req && !hit) begin
                    base_d  = {cpu_addr[31:WB+2], {(WB+2){1'b0}}};
                    beat_d  = '0;
                    state_d = S_REFILL;
                    // a flush coinciding with a miss waits until the new line lands
                    if (flush) flush_pend_d = 1'b1;
                end else if (flush) begin
                    valid_d = '0;
                end
            end
            S_REFILL: begin
                if (flush) flush_pend_d = 1'b1;
                if (wb_ack_i) begin
                    beat_d = beat_q + WB'(1);
                    if (last_beat) begin
                        valid_d[fill_idx] = 1'b1;
                        state_d           = S_RESP;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (flush || flush_pend_q) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            base_q       <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && data_we) begin
            data_mem[fill_idx][beat_q] <= wb_data_i;
            if (last_beat) tag_mem[fill_idx] <= fill_tag;
        end
    end

    assign wb_stb_o  = (state_q == S_REFILL);
    assign wb_cyc_o  = (state_q == S_REFILL);
    assign wb_addr_o = (state_q == S_REFILL) ? (base_q + {{(30-WB){1'b0}}, beat_q, 2'b00}) : 32'h0;
    assign wb_data_o = 32'h0;
    assign wb_we_o   = 1'b0;
    assign wb_sel_o  = 4'hF;

    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = 32'h0;
        if (state_q == S_IDLE && cpu_req && hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = data_mem[req_idx][req_word];
        end else if (state_q == S_RESP) begin
            cpu_ready = 1'b1;
            cpu_rdata = data_mem[fill_idx][req_word];
        end
    end
endmodule

// File: doc/icache_wb.md
# icache_wb

Direct-mapped, read-only L1 instruction cache between the CPU instruction-fetch port and the Wishbone interconnect's master-1 port. On a hit it answers the fetch in the same cycle. On a miss it stalls the CPU and refills the whole line from the instruction ROM with single-beat classic Wishbone reads, then returns the requested word. It replaces the CPU's direct iwishbone connection. Downstream, the interconnect and INSTROM see only line-aligned word reads.

## Interface
- LINE_WORDS, 4: words per line; power of two, ≥2.
- SETS, 64: number of lines; power of two.
- Address split:
  - byte offset = addr[1:0], ignored;
  - word = addr[WB+1:2], where WB = log2(LINE_WORDS);
  - index = next IB bits, where IB = log2(SETS);
  - tag = remaining upper bits.
- Defaults: word [3:2], index [9:4], tag [31:10].

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  fetch request; held with cpu_addr stable until cpu_ready.
- cpu_addr  in  32  fetch byte address.
- cpu_rdata  out  32  fetched word; valid only while cpu_ready=1.
- cpu_ready  out  1  fetch complete this cycle (0 = stall).
- flush  in  1  one-cycle pulse; invalidate all lines.
- wb_addr_o  out  32  Wishbone address.
- wb_data_o  out  32  constant 0.
- wb_we_o  out  1  constant 0.
- wb_sel_o  out  4  constant 4'hF.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle.
- wb_data_i  in  32  read data.
- wb_ack_i  in  1  beat acknowledge.

## Operation
- Storage: per set, one valid bit, one tag and LINE_WORDS data words. Reads are asynchronous; writes are clocked.
- Hit condition: valid[index] && tag[index]==cpu_addr tag.
- FSM state IDLE:
  - cpu_req && hit: cpu_ready=1 combinationally; cpu_rdata = data[index][word].
  - cpu_req && miss: cpu_ready=0. Latch line base = {tag, index, zeros}. Clear beat counter. Go to REFILL.
  - flush (and no miss this cycle): clear all valid bits at the edge.
- FSM state REFILL:
  - wb_cyc_o=wb_stb_o=1; wb_addr_o = line base + 4*beat.
  - On wb_ack_i: write wb_data_i into data[index][beat], then increment beat.
  - After the last ack (beat LINE_WORDS-1): write tag, set valid, go to RESP.
  - Wait states: stb/cyc/addr are held unchanged until ack.
- FSM state RESP:
  - cpu_ready=1 for exactly one cycle; cpu_rdata = newly filled word. Go to IDLE.
- Flush during REFILL or RESP:
  - The pulse is latched as pending.
  - The pending flush is applied on entry to IDLE, after the new line is marked valid. The current fetch still completes with correct data.
- cpu_ready is 0 in every cycle of REFILL.
- wb_ack_i is ignored outside REFILL.
- Refill order is always line base upward (no critical-word-first).
- The CPU must not change cpu_addr while stalled; behaviour otherwise is undefined.

## Timing
- Reset values:
  - cpu_ready=0, cpu_rdata=0 (when not ready, cpu_rdata outputs 0);
  - wb_stb_o=wb_cyc_o=0, wb_addr_o=0;
  - FSM=IDLE, beat=0, all valid=0, flush pending=0.
- Reset during REFILL: stb/cyc deassert at that edge. The partial line is not validated, and any late ack is ignored.
- Hit latency: 0 cycles (same-cycle cpu_ready).
- Miss, miss-detect at cycle T:
  - stb/cyc rise at T+1.
  - With ack returned every cycle: acks at T+1..T+LINE_WORDS; cpu_ready=1 at T+LINE_WORDS+1.
  - In general, cpu_ready is asserted the cycle after the final ack.
- Back-to-back: a request in the cycle after RESP is looked up normally, so a hit there returns in 0 cycles.

## Test plan
- Cold miss:
  - Stimulus: after reset, fetch 0x0000_0108; ROM words at 0x100/104/108/10C = A0,A1,A2,A3; ack every cycle.
  - Required: wb reads 0x100,0x104,0x108,0x10C in order; cpu_ready one cycle after the last ack with rdata=A2.
  - Then fetch 0x10C: same-cycle ready, rdata=A3, no wb_stb_o.
- Conflict eviction:
  - After the line at 0x100 is filled, fetch 0x500 (same index 0x10): refill of 0x500..0x50C occurs.
  - Refetch 0x100: a miss again, with a full refill.
- Wait states:
  - Slave delays each ack by 3 cycles.
  - Required: stb/cyc/addr stable during waits; 4 beats complete; ready follows the 4th ack; correct data.
- Flush:
  - Flush pulse in IDLE: the next fetch of 0x108 misses.
  - Flush pulse during the 2nd refill beat: the current fetch completes with correct data, and an immediate refetch of the same address misses.
- Reset mid-refill:
  - Assert rst after the 2nd ack.
  - Required: stb/cyc=0 the next cycle, all outputs at reset values; the following fetch of the same line misses and refills all 4 words.
